// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first; rx_valid 3 clk after the final synchronized sclk rise; tx_data accepted only while tx_ready (buffer empty).
// Optional rx_overrun/rx_ack unread-word tracking is compiled in with SPI_SLAVE_OVERRUN_EN.
module spi_slave #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  input  logic                  rx_ack,
  output logic                  rx_overrun
`endif
);

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                state;
  logic [2:0]            sclk_s;
  logic [2:0]            cs_s;
  logic [1:0]            mosi_s;
  logic [1:0]            sync_vld;
  logic                  armed;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] tx_buf;
  logic                  buf_full;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic                  unread;
`endif

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s   <= 3'b000;
      cs_s     <= 3'b111;
      mosi_s   <= 2'b00;
      sync_vld <= 2'b00;
    end else begin
      sclk_s   <= {sclk_s[1:0], sclk};
      cs_s     <= {cs_s[1:0], cs_n};
      mosi_s   <= {mosi_s[0], mosi};
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall = ~sclk_s[1] & sclk_s[2];
  assign cs_rise   = cs_s[1] & ~cs_s[2];
  assign cs_fall   = ~cs_s[1] & cs_s[2];
  assign mosi_b    = mosi_s[1];

  assign miso     = ~cs_s[1] & tx_shift[DATA_WIDTH-1];
  assign tx_ready = ~buf_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      armed    <= 1'b0;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      tx_buf   <= '0;
      buf_full <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
      unread     <= 1'b0;
      rx_overrun <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
      rx_overrun <= 1'b0;
      if (rx_ack) unread <= 1'b0;
`endif
      // A cs_n low level seen straight out of reset is not a fresh select edge.
      armed <= armed | (sync_vld[1] & cs_s[1]);

      if (tx_valid && !buf_full) begin
        tx_buf   <= tx_data;
        buf_full <= 1'b1;
      end

      if (cs_rise) begin
        state   <= IDLE;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (cs_fall && armed) state <= LOAD;
          LOAD: begin
            if (buf_full) begin
              tx_shift <= tx_buf;
              buf_full <= 1'b0;
            end else begin
              tx_shift <= '0;
            end
            state <= SHIFT;
          end
          SHIFT: begin
            if (sclk_rise) begin
              rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_b};
              if (bit_cnt == LAST_BIT) begin
                rx_data  <= {rx_shift[DATA_WIDTH-2:0], mosi_b};
                rx_valid <= 1'b1;
                bit_cnt  <= '0;
                state    <= LOAD;
`ifdef SPI_SLAVE_OVERRUN_EN
                unread     <= 1'b1;
                rx_overrun <= unread & ~rx_ack;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (sclk_fall && bit_cnt != '0) begin
              // The fall after a frame's last rise must not shift the freshly loaded word.
              tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: mode-0 master at clk/8, tx handshakes, aborts, reset and optional overrun.
module tb_spi_slave;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       rx_ack;
  logic       rx_overrun;
  int         ov_cnt = 0;
`endif

  int checks   = 0;
  int failures = 0;
  int rxv_cnt  = 0;
  int base;
  bit lat_hit;
  logic [7:0] mi, mi2;

  spi_slave #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    .rx_ack     (rx_ack),
    .rx_overrun (rx_overrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) rxv_cnt++;
`ifdef SPI_SLAVE_OVERRUN_EN
    if (rx_overrun) ov_cnt++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] v);
    @(negedge clk);
    tx_data  = v;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

`ifdef SPI_SLAVE_OVERRUN_EN
  task automatic ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask
`endif

  // Master drives mosi for half a period, raises sclk (sampling miso there), then lowers it.
  task automatic frame(input logic [7:0] mo, input int nbits, input bit refill,
                       input logic [7:0] rval, output logic [7:0] got);
    int start;
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      wait_clk(4);
      sclk = 1'b1;
      got[7-i] = miso;
      start = rxv_cnt;
      if (refill && i == 4) push(rval);
      wait_clk(4);
      if (i == nbits - 1) lat_hit = (rxv_cnt != start);
      sclk = 1'b0;
    end
  endtask

  task automatic select();
    cs_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic deselect();
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  initial begin
    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
    rx_ack = 1'b0;
`endif
    wait_clk(3);
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_miso", miso, 0);
    rst_n = 1'b1;
    wait_clk(5);

    // Handshaken A5 goes out while 3C comes in.
    push(8'hA5);
    chk("t1_tx_ready_drop", tx_ready, 0);
    base = rxv_cnt;
    select();
    frame(8'h3C, 8, 1'b0, 8'h00, mi);
    deselect();
    chk("t1_miso_word", mi, 8'hA5);
    chk("t1_rx_data", rx_data, 8'h3C);
    chk("t1_rx_pulses", rxv_cnt - base, 1);
    chk("t1_rx_latency", lat_hit, 1);
    chk("t1_tx_ready_back", tx_ready, 1);

    // Empty buffer sends zeros.
    base = rxv_cnt;
    select();
    frame(8'hFF, 8, 1'b0, 8'h00, mi);
    deselect();
    chk("t2_miso_zero", mi, 8'h00);
    chk("t2_rx_data", rx_data, 8'hFF);
    chk("t2_rx_pulses", rxv_cnt - base, 1);

    // Back-to-back frames with a refill during the first.
    push(8'h96);
    base = rxv_cnt;
    select();
    frame(8'h01, 8, 1'b1, 8'h55, mi);
    chk("t3_rx_data_first", rx_data, 8'h01);
    frame(8'h80, 8, 1'b0, 8'h00, mi2);
    deselect();
    chk("t3_miso_first", mi, 8'h96);
    chk("t3_miso_second", mi2, 8'h55);
    chk("t3_rx_data_second", rx_data, 8'h80);
    chk("t3_rx_pulses", rxv_cnt - base, 2);

    // Abort after 5 bits; word pushed mid-frame survives for the next frame.
    base = rxv_cnt;
    select();
    frame(8'hA0, 5, 1'b1, 8'h5A, mi);
    deselect();
    chk("t4_abort_pulses", rxv_cnt - base, 0);
    chk("t4_rx_data_kept", rx_data, 8'h80);
    chk("t4_buffer_kept", tx_ready, 0);
    base = rxv_cnt;
    select();
    frame(8'hC3, 8, 1'b0, 8'h00, mi);
    deselect();
    chk("t4_rx_data_next", rx_data, 8'hC3);
    chk("t4_miso_retained", mi, 8'h5A);
    chk("t4_rx_pulses_next", rxv_cnt - base, 1);

    // Reset mid-frame.
    push(8'h77);
    base = rxv_cnt;
    select();
    frame(8'hE7, 3, 1'b0, 8'h00, mi);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_tx_ready", tx_ready, 1);
    chk("t5_rx_valid", rx_valid, 0);
    chk("t5_rx_data", rx_data, 8'h00);
    chk("t5_miso", miso, 0);
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(10);
    chk("t5_no_pulse_after_release", rxv_cnt - base, 0);
    cs_n = 1'b1;
    wait_clk(8);
    base = rxv_cnt;
    select();
    frame(8'h69, 8, 1'b0, 8'h00, mi);
    deselect();
    chk("t5_recover_rx_data", rx_data, 8'h69);
    chk("t5_recover_pulses", rxv_cnt - base, 1);

`ifdef SPI_SLAVE_OVERRUN_EN
    ack();
    base = ov_cnt;
    select();
    frame(8'h11, 8, 1'b0, 8'h00, mi);
    chk("t6_no_overrun_first", ov_cnt - base, 0);
    frame(8'h22, 8, 1'b0, 8'h00, mi);
    deselect();
    chk("t6_overrun_once", ov_cnt - base, 1);
    ack();
    base = ov_cnt;
    select();
    frame(8'h33, 8, 1'b0, 8'h00, mi);
    deselect();
    ack();
    select();
    frame(8'h44, 8, 1'b0, 8'h00, mi);
    deselect();
    chk("t6_acked_no_overrun", ov_cnt - base, 0);
    chk("t6_rx_data", rx_data, 8'h44);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
